// File: rtl/sequence_checker_pkg.sv
// Shared constants, game-state codes and digit helpers for the sequence checker
// and its display decoder.
package sequence_checker_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEQ_LEN = 6;
  localparam int POS_W   = 3;
  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    INICIAL         = 4'd0,
    CERTO1_ERRO0    = 4'd1,
    CERTO2_ERRO0    = 4'd2,
    CERTO3_ERRO0    = 4'd3,
    CERTO4_ERRO0    = 4'd4,
    CERTO5_ERRO0    = 4'd5,
    SUCESSO_TOTAL   = 4'd6,
    CERTO0_ERRO1    = 4'd7,
    CERTO1_ERRO1    = 4'd8,
    CERTO2_ERRO1    = 4'd9,
    CERTO3_ERRO1    = 4'd10,
    CERTO4_ERRO1    = 4'd11,
    CERTO5_ERRO1    = 4'd12,
    SUCESSO_PARCIAL = 4'd13,
    FALHA           = 4'd14
  } state_t;

  // Offset between CERTOk_ERRO0 and CERTOk_ERRO1.
  localparam logic [STATE_W-1:0] ERRO1_OFFSET = 4'd7;

  function automatic logic is_terminal(input state_t s);
    return (s == SUCESSO_TOTAL) || (s == SUCESSO_PARCIAL) || (s == FALHA);
  endfunction

  function automatic logic has_error(input state_t s);
    return (s >= CERTO0_ERRO1) && (s <= CERTO5_ERRO1);
  endfunction

  // A first miss moves to the matching ERRO1 state; a second miss is fatal.
  function automatic state_t next_on_miss(input state_t s);
    return has_error(s) ? FALHA : state_t'(s + ERRO1_OFFSET);
  endfunction

  function automatic logic [DIGIT_W-1:0] secret_digit(
    input logic [DIGIT_W*SEQ_LEN-1:0] seq,
    input logic [POS_W-1:0]           pos
  );
    return seq[(SEQ_LEN - 1 - int'(pos)) * DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/entry_timer.sv
// Idle-entry timer: counts cycles while run is high and pulses expired on the
// last cycle of each TIMEOUT_CICLOS window.
module entry_timer #(
  parameter int TIMEOUT_CICLOS = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CICLOS - 1);

  logic [CNT_W-1:0] cnt;

  assign expired = run && !clear && (cnt == CNT_LAST);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear || !run || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sequence_checker.sv
// Six-digit sequence guessing game with one allowed retry.
// Optional idle timeout is built when ENTRY_TIMEOUT_EN is defined.
module sequence_checker
  import sequence_checker_pkg::*;
#(
  parameter logic [DIGIT_W*SEQ_LEN-1:0] SEQUENCIA      = 24'h314159,
  parameter int                         TIMEOUT_CICLOS = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] entrada,
  input  logic               entrada_valida,
  input  logic               reiniciar,
  output logic [STATE_W-1:0] estado,
  output logic [DIGIT_W-1:0] digito,
  output logic [POS_W-1:0]   posicao
);

  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
  localparam logic [POS_W-1:0]   LAST_POS  = POS_W'(SEQ_LEN - 1);

  state_t             state, state_n;
  logic [POS_W-1:0]   pos, pos_n;
  logic [DIGIT_W-1:0] dig, dig_n;
  logic               accept;
  logic               correct;
  logic               timeout_fire;

  assign accept  = entrada_valida && (entrada <= MAX_DIGIT) && !reiniciar
                   && !is_terminal(state);
  assign correct = (entrada == secret_digit(SEQUENCIA, pos));

`ifdef ENTRY_TIMEOUT_EN
  logic timer_run;

  // The clock only runs once a game is in progress.
  assign timer_run = !is_terminal(state) && (state != INICIAL);

  entry_timer #(
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
  ) u_entry_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept || reiniciar),
    .run     (timer_run),
    .expired (timeout_fire)
  );
`else
  logic unused_timeout;

  assign timeout_fire   = 1'b0;
  assign unused_timeout = ^TIMEOUT_CICLOS;
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    pos_n   = pos;
    dig_n   = dig;
    if (reiniciar) begin
      state_n = INICIAL;
      pos_n   = '0;
      dig_n   = '0;
    end else if (accept) begin
      dig_n = entrada;
      if (correct) begin
        // Codes are laid out so a hit is always the next code, including
        // CERTO5_ERRO0 -> SUCESSO_TOTAL and CERTO5_ERRO1 -> SUCESSO_PARCIAL.
        state_n = state_t'(state + 4'd1);
        if (pos != LAST_POS) begin
          pos_n = pos + 1'b1;
        end
      end else begin
        state_n = next_on_miss(state);
      end
    end else if (timeout_fire) begin
      state_n = next_on_miss(state);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INICIAL;
      pos   <= '0;
      dig   <= '0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
      dig   <= dig_n;
    end
  end

  assign estado  = state;
  assign digito  = dig;
  assign posicao = pos;

endmodule

// File: tb/tb_sequence_checker.sv
// Self-checking bench for sequence_checker: game-level reference model plus
// directed scenarios with literal expectations.
module tb_sequence_checker;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] entrada = '0;
  logic       entrada_valida = 1'b0;
  logic       reiniciar = 1'b0;
  logic [3:0] estado;
  logic [3:0] digito;
  logic [2:0] posicao;

  sequence_checker #(
    .SEQUENCIA      (24'h314159),
    .TIMEOUT_CICLOS (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .entrada        (entrada),
    .entrada_valida (entrada_valida),
    .reiniciar      (reiniciar),
    .estado         (estado),
    .digito         (digito),
    .posicao        (posicao)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Game-level model: hits so far, whether the one retry is spent, failure.
  int secret [6] = '{3, 1, 4, 1, 5, 9};
  int m_hits = 0, m_err = 0, m_fail = 0, m_pos = 0, m_dig = 0, m_idle = 0;

  function automatic int model_estado();
    if (m_fail != 0) return 14;
    if (m_hits == 6) return (m_err != 0) ? 13 : 6;
    return (m_err != 0) ? 7 + m_hits : m_hits;
  endfunction

  function automatic bit model_terminal();
    return (m_fail != 0) || (m_hits == 6);
  endfunction

  task automatic model_miss();
    if (m_err != 0) m_fail = 1;
    else            m_err  = 1;
  endtask

  always @(posedge clk) begin
    if (reset || reiniciar) begin
      m_hits = 0; m_err = 0; m_fail = 0; m_pos = 0; m_dig = 0; m_idle = 0;
    end else if (!model_terminal()) begin
      if (entrada_valida && (int'(entrada) <= 9)) begin
        m_dig  = int'(entrada);
        m_idle = 0;
        if (int'(entrada) == secret[m_pos]) begin
          m_hits++;
          if (m_pos < 5) m_pos++;
        end else begin
          model_miss();
        end
      end
`ifdef ENTRY_TIMEOUT_EN
      else if (m_hits > 0 || m_err > 0) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_idle = 0;
          model_miss();
        end
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model_estado", int'(estado), model_estado());
      check("model_posicao", int'(posicao), m_pos);
      check("model_digito", int'(digito), m_dig);
    end
  end

  task automatic strobe_seq(input string tag, input int n, input int digs[7], input int exps[7]);
    for (int i = 0; i < n; i++) begin
      entrada        = 4'(digs[i]);
      entrada_valida = 1'b1;
      @(posedge clk); #1;
      check($sformatf("%s_estado%0d", tag, i), int'(estado), exps[i]);
    end
    entrada_valida = 1'b0;
  endtask

  task automatic strobe1(input int d, input bit rst_too);
    entrada        = 4'(d);
    entrada_valida = 1'b1;
    reiniciar      = rst_too;
    @(posedge clk); #1;
    entrada_valida = 1'b0;
    reiniciar      = 1'b0;
  endtask

  task automatic restart();
    reiniciar = 1'b1;
    @(posedge clk); #1;
    reiniciar = 1'b0;
  endtask

  task automatic idle(input int n);
    entrada_valida = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    check_en = 1'b1;
    check("reset_estado", int'(estado), 0);
    check("reset_posicao", int'(posicao), 0);
    check("reset_digito", int'(digito), 0);

    // Perfect game, then a strobe in the terminal state is ignored.
    strobe_seq("total", 6, '{3, 1, 4, 1, 5, 9, 0}, '{1, 2, 3, 4, 5, 6, 0});
    check("total_posicao", int'(posicao), 5);
    check("total_digito", int'(digito), 9);
    strobe1(3, 1'b0);
    check("total_hold", int'(estado), 6);
    check("total_hold_dig", int'(digito), 9);

    restart();
    check("restart_estado", int'(estado), 0);
    check("restart_digito", int'(digito), 0);

    // One miss then a full recovery.
    strobe_seq("parcial", 7, '{3, 7, 1, 4, 1, 5, 9}, '{1, 8, 9, 10, 11, 12, 13});
    check("parcial_posicao", int'(posicao), 5);

    // Two misses end the game; later strobes are ignored.
    restart();
    strobe_seq("falha", 3, '{3, 7, 0, 0, 0, 0, 0}, '{1, 8, 14, 0, 0, 0, 0});
    strobe1(1, 1'b0);
    check("falha_hold", int'(estado), 14);
    check("falha_digito", int'(digito), 0);
    check("falha_posicao", int'(posicao), 1);

    // Invalid digit and restart-overrides-strobe.
    restart();
    strobe1(12, 1'b0);
    check("bad_digit_estado", int'(estado), 0);
    check("bad_digit_digito", int'(digito), 0);
    strobe1(3, 1'b1);
    check("restart_wins", int'(estado), 0);
    check("restart_wins_dig", int'(digito), 0);

    // Miss on the very first digit, then retry.
    strobe1(5, 1'b0);
    check("first_miss", int'(estado), 7);
    check("first_miss_pos", int'(posicao), 0);
    strobe1(3, 1'b0);
    check("first_retry", int'(estado), 8);

    // Reset mid-game.
    restart();
    strobe_seq("mid", 2, '{3, 1, 0, 0, 0, 0, 0}, '{1, 2, 0, 0, 0, 0, 0});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_estado", int'(estado), 0);
    check("midreset_posicao", int'(posicao), 0);
    check("midreset_digito", int'(digito), 0);

    // Idle behaviour after one hit.
    strobe1(3, 1'b0);
`ifdef ENTRY_TIMEOUT_EN
    idle(TMO - 1);
    check("tmo_not_yet", int'(estado), 1);
    idle(1);
    check("tmo_first", int'(estado), 8);
    idle(TMO);
    check("tmo_second", int'(estado), 14);
`else
    idle(3 * TMO);
    check("no_timeout", int'(estado), 1);
`endif

    // Mixed random traffic, checked by the model alone.
    for (int g = 0; g < 6; g++) begin
      restart();
      for (int c = 0; c < 20; c++) begin
        entrada_valida = ($urandom_range(0, 3) != 0);
        entrada = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'(secret[m_pos]);
        reiniciar = ($urandom_range(0, 40) == 0);
        @(posedge clk); #1;
      end
      entrada_valida = 1'b0;
      reiniciar      = 1'b0;
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
